// File: rtl/div_unit.sv
// Iterative rv32im divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, with single-cycle handling of div-by-zero and overflow.
//
// state | meaning
// IDLE  | waiting for valid; captures operands
// CALC  | WIDTH shift-subtract iterations
// DONE  | result valid, ready pulse for one cycle
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_signed;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  // op[0]=0 selects the signed variants (DIV/REM)
  assign is_signed = ~op[0];
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == MIN_NEG) && (b == ALL_ONES);
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shift and the sign of the trial subtract.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], q_bit};
  assign quo_fin = neg_quo_q ? -quo_nxt : quo_nxt;
  assign rem_fin = neg_rem_q ? -rem_nxt : rem_nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          quo_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          is_rem_d  = op[1];
          neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = is_signed & a[WIDTH-1];
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = op[1] ? a : ALL_ONES;
          end else if (ovf) begin
            state_d  = S_DONE;
            result_d = op[1] ? '0 : MIN_NEG;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        quo_d = quo_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          result_d = is_rem_q ? rem_fin : quo_fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == S_DONE);
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected result and latency queued at issue,
// popped and compared when ready pulses.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sboard[$];

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .ready  (ready),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = av;
    sbv = bv;
    if (bv == 32'd0) return o[1] ? av : 32'hFFFF_FFFF;
    if (!o[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return sa / sbv;
      OP_DIVU: return av / bv;
      OP_REM:  return sa % sbv;
      default: return av % bv;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    if (bv == 32'd0) return 1;
    if (!o[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Entered and left at a negedge; on return the unit is in the IDLE cycle after DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat,
                        input int poke_cyc);
    exp_t e;
    exp_t got_e;
    bit   seen;
    seen  = 1'b0;
    e.res = exp_res;
    e.lat = exp_lat;
    sboard.push_back(e);
    op    = o;
    a     = av;
    b     = bv;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (cyc == poke_cyc) begin
        valid = 1'b1;
        a     = 32'd999;
        b     = 32'd5;
      end else begin
        valid = 1'b0;
      end
      check({tag, ".busy"}, 32'(busy), 32'(cyc <= exp_lat));
      if (ready) begin
        seen = 1'b1;
        if (sboard.size() == 0) begin
          check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
          got_e = sboard.pop_front();
          check({tag, ".lat"}, 32'(cyc), 32'(got_e.lat));
          check({tag, ".res"}, result, got_e.res);
        end
      end
      @(negedge clk);
    end
    valid = 1'b0;
    if (!seen) check({tag, ".timeout"}, 32'd0, 32'd1);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_ready"}, 32'(ready), 32'd0);
    check({tag, ".hold"}, result, exp_res);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.result", result, 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    resetn = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", OP_REMU, 32'h1234, 32'd0, 32'h0000_1234, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("rem_min_3", OP_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 33, 0);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);

    // Second request in cycle 10 must be dropped; the next one follows DONE directly.
    run_op("busy_first", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33, 10);
    run_op("busy_next", OP_DIVU, 32'd50, 32'd5, 32'd10, 33, 0);

    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      check("abort.no_ready", 32'(ready), 32'd0);
      @(negedge clk);
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort.result", result, 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ready", 32'(ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("remu_10_3", OP_REMU, 32'd10, 32'd3, 32'd1, 33, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb), 0);
    end

    check("sb.drained", 32'(sboard.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is supported for rv32im.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: valid  input  1  start request; sampled only while the unit is idle.
REQ-005 Port: op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the M-extension divide group).
REQ-006 Port: a  input  WIDTH  dividend (rs1 value).
REQ-007 Port: b  input  WIDTH  divisor (rs2 value).
REQ-008 Port: result  output  WIDTH  quotient or remainder per op; registered.
REQ-009 Port: ready  output  1  single-cycle pulse; result is valid in that cycle.
REQ-010 Port: busy  output  1  high in every non-IDLE state.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE with valid=1, the unit SHALL capture a, b and op at the next edge (the accept edge); a, b and op SHALL be don't-care afterwards.
REQ-013 Acceptance rule: div-by-zero (b==0) or signed overflow (op=DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL go IDLE->DONE; every other accepted request SHALL go IDLE->CALC.
REQ-014 CALC SHALL run a restoring shift-subtract division on operand magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, using an internal iteration counter that resets to 0 on accept.
REQ-015 After the WIDTH-th CALC cycle the FSM SHALL enter DONE; DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-016 ready SHALL be 1 only in DONE.
REQ-017 Latency: with the accept cycle numbered 0, ready SHALL be high in cycle WIDTH+1 (33) on the normal path and in cycle 1 on the special-case path.
REQ-018 valid SHALL be ignored while busy=1, with no queuing; a request may be accepted in the IDLE cycle immediately following DONE.
REQ-019 For signed operations (DIV/REM), the quotient SHALL be negated when sign(a)!=sign(b), and the remainder SHALL take the sign of a; magnitudes SHALL be computed in two's complement, so |0x80000000| = 0x80000000 unsigned.
REQ-020 Unsigned operations (DIVU/REMU) SHALL use a and b unmodified.
REQ-021 Division by zero SHALL produce: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = a.
REQ-022 Signed overflow SHALL produce: DIV result = 0x80000000; REM result = 0.
REQ-023 result SHALL be written on entry to DONE and held unchanged until the next entry to DONE.
REQ-024 The iteration counter SHALL be 6 bits wide, SHALL NOT wrap during CALC, and SHALL be cleared on accept.

Reset
REQ-025 While resetn=0 at a clock edge, the unit SHALL set: state IDLE, result 0, ready 0, busy 0, counter 0, internal operand and remainder registers 0.
REQ-026 A reset asserted in CALC or DONE SHALL abort the operation with no ready pulse; the first cycle after reset release SHALL be able to accept a request.

Verification
REQ-027 Reset then DIVU, a=100, b=7, valid for one cycle -> busy=1 in cycles 1-33; ready=1 only in cycle 33; result=14.
REQ-028 Signed sign rules -> REM a=-7 (0xFFFFFFF9), b=2 returns 0xFFFFFFFF (-1); DIV a=-7, b=2 returns 0xFFFFFFFD (-3); DIV a=7, b=-2 returns 0xFFFFFFFD.
REQ-029 Division by zero -> DIVU a=0x1234, b=0 gives ready in cycle 1 with result 0xFFFFFFFF; REMU with the same operands gives 0x1234; busy=1 only in cycle 1.
REQ-030 Signed overflow -> DIV a=0x80000000, b=0xFFFFFFFF gives ready in cycle 1 with result 0x80000000; REM with the same operands gives 0.
REQ-031 Request during busy -> a second valid with different a/b in cycle 10 is ignored; the first result is unchanged at cycle 33; a new valid in cycle 34 is accepted and its ready appears at cycle 67.
REQ-032 Reset mid-operation -> resetn=0 in cycle 20 of a DIVU gives no ready pulse, and result=0, busy=0 after that edge; a new REMU a=10, b=3 yields result=1 at its cycle 33.
